// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID check master.
//   state_e : FSM state encoding (idle, read ID, read timestamp, finished)
//   ADDR_ID : slave word address of the system ID register
//   ADDR_TS : slave word address of the timestamp register
package sysid_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRdId = 2'd1,
    StRdTs = 2'd2,
    StFin  = 2'd3
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_check_master.sv
// Avalon-MM master that reads the system ID (word 0) and timestamp (word 1) from a sysid slave
// and compares them against expected values. One check runs automatically after reset; a
// start pulse in IDLE or FIN re-runs it.
//
// Ports:
//   clock, reset_n          : rising-edge clock, asynchronous active-low reset
//   start                   : one-cycle re-run request (ignored while busy)
//   avm_address, avm_read   : Avalon-MM master request
//   avm_waitrequest         : slave stall
//   avm_readdata            : slave read data
//   busy, done              : check in progress / check finished
//   pass, id_ok, ts_ok      : comparison results
//   timeout                 : a read stalled for TIMEOUT_CYCLES cycles
//   id_value, ts_value      : captured words
module sysid_check_master
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h606A_5FA0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] stall_q, stall_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic        stalled;
  logic [15:0] stall_inc;

  assign accept    = avm_read_q & ~avm_waitrequest;
  assign stalled   = avm_read_q & avm_waitrequest;
  assign stall_inc = stall_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    stall_d    = stall_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      // Leaving IDLE is unconditional so a check runs once after reset release.
      StIdle: begin
        state_d    = StRdId;
        id_value_d = '0;
        ts_value_d = '0;
        id_ok_d    = 1'b0;
        ts_ok_d    = 1'b0;
        timeout_d  = 1'b0;
      end
      StRdId: begin
        if (accept) begin
          id_value_d = avm_readdata;
          id_ok_d    = (avm_readdata == EXPECTED_ID);
          state_d    = StRdTs;
        end else if (stalled) begin
          // Abort on the edge that would count the TIMEOUT_CYCLES-th stalled cycle.
          if (stall_inc == TimeoutLim) begin
            timeout_d = 1'b1;
            state_d   = StFin;
          end else begin
            stall_d = stall_inc;
          end
        end
      end
      StRdTs: begin
        if (accept) begin
          ts_value_d = avm_readdata;
          ts_ok_d    = (avm_readdata == EXPECTED_TS);
          state_d    = StFin;
        end else if (stalled) begin
          if (stall_inc == TimeoutLim) begin
            timeout_d = 1'b1;
            state_d   = StFin;
          end else begin
            stall_d = stall_inc;
          end
        end
      end
      StFin: begin
        if (start) begin
          state_d    = StRdId;
          id_value_d = '0;
          ts_value_d = '0;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Each read gets a fresh stall budget.
    if (state_d != state_q) begin
      stall_d = '0;
    end

    pass_d        = id_ok_d & ts_ok_d & ~timeout_d;
    avm_read_d    = (state_d == StRdId) || (state_d == StRdTs);
    busy_d        = avm_read_d;
    done_d        = (state_d == StFin);
    avm_address_d = (state_d == StRdTs) ? ADDR_TS : ADDR_ID;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      stall_q       <= '0;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      avm_read_q    <= 1'b0;
      avm_address_q <= ADDR_ID;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      stall_q       <= stall_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign avm_address = avm_address_q;
  assign avm_read    = avm_read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench for sysid_check_master: one instance against a configurable-wait slave model,
// a second instance (TIMEOUT_CYCLES=4) against a slave whose waitrequest is stuck high.
module tb_sysid_check_master;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, reset2_n, start;
  logic [31:0] id_word, ts_word;
  int          wait_states;
  int          slv_cnt;

  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  logic        t_address, t_read, t_busy, t_done, t_pass, t_id_ok, t_ts_ok, t_timeout;
  logic [31:0] t_id_value, t_ts_value;

  int vectors    = 0;
  int miscompares = 0;

  // Slave: stall wait_states cycles on each read, then return the addressed word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) slv_cnt <= 0;
    else if (avm_read && avm_waitrequest) slv_cnt <= slv_cnt + 1;
    else slv_cnt <= 0;
  end
  assign avm_waitrequest = avm_read && (slv_cnt < wait_states);
  assign avm_readdata    = avm_address ? ts_word : id_word;

  sysid_check_master dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout        (timeout),
    .id_value       (id_value),
    .ts_value       (ts_value)
  );

  sysid_check_master #(.TIMEOUT_CYCLES(4)) dut_to (
    .clock          (clock),
    .reset_n        (reset2_n),
    .start          (1'b0),
    .avm_address    (t_address),
    .avm_read       (t_read),
    .avm_waitrequest(1'b1),
    .avm_readdata   (32'hDEAD_BEEF),
    .busy           (t_busy),
    .done           (t_done),
    .pass           (t_pass),
    .id_ok          (t_id_ok),
    .ts_ok          (t_ts_ok),
    .timeout        (t_timeout),
    .id_value       (t_id_value),
    .ts_value       (t_ts_value)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset_n     = 1'b0;
    reset2_n    = 1'b0;
    start       = 1'b0;
    id_word     = 32'h0000_0000;
    ts_word     = 32'h606A_5FA0;
    wait_states = 0;

    // Reset state
    #12;
    chk1("rst_read", avm_read, 1'b0);
    chk1("rst_addr", avm_address, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_pass", pass, 1'b0);
    chk("rst_id_value", id_value, 32'h0);
    reset_n = 1'b1;

    // Zero-wait automatic check: RD_ID, RD_TS, FIN at cycles 1..3
    step();
    chk1("zw_c1_read", avm_read, 1'b1);
    chk1("zw_c1_addr", avm_address, 1'b0);
    chk1("zw_c1_busy", busy, 1'b1);
    step();
    chk1("zw_c2_addr", avm_address, 1'b1);
    chk1("zw_c2_done", done, 1'b0);
    step();
    chk1("zw_c3_done", done, 1'b1);
    chk1("zw_c3_busy", busy, 1'b0);
    chk1("zw_c3_read", avm_read, 1'b0);
    chk1("zw_pass", pass, 1'b1);
    chk1("zw_id_ok", id_ok, 1'b1);
    chk1("zw_ts_ok", ts_ok, 1'b1);
    chk1("zw_timeout", timeout, 1'b0);
    chk("zw_ts_value", ts_value, 32'h606A_5FA0);

    // ID mismatch via start in FIN; flags clear on the start edge
    id_word = 32'h0000_0001;
    start   = 1'b1;
    step();
    start = 1'b0;
    chk1("idm_clr_done", done, 1'b0);
    chk1("idm_clr_pass", pass, 1'b0);
    chk("idm_clr_ts_value", ts_value, 32'h0);
    chk1("idm_busy", busy, 1'b1);
    step();
    step();
    chk1("idm_done", done, 1'b1);
    chk1("idm_id_ok", id_ok, 1'b0);
    chk1("idm_ts_ok", ts_ok, 1'b1);
    chk1("idm_pass", pass, 1'b0);
    chk("idm_id_value", id_value, 32'h0000_0001);

    // Timestamp off by one
    id_word = 32'h0000_0000;
    ts_word = 32'h606A_5FA1;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk1("tsm_done", done, 1'b1);
    chk1("tsm_id_ok", id_ok, 1'b1);
    chk1("tsm_ts_ok", ts_ok, 1'b0);
    chk1("tsm_pass", pass, 1'b0);
    chk("tsm_ts_value", ts_value, 32'h606A_5FA1);

    // 5 wait states per read, start pulsed during the RD_TS stall must be ignored
    ts_word     = 32'h606A_5FA0;
    wait_states = 5;
    start       = 1'b1;
    step();
    for (int c = 1; c <= 12; c++) begin
      chk1($sformatf("ws_c%0d_read", c), avm_read, 1'b1);
      chk1($sformatf("ws_c%0d_addr", c), avm_address, (c <= 6) ? 1'b0 : 1'b1);
      chk1($sformatf("ws_c%0d_done", c), done, 1'b0);
      start = (c == 9);
      step();
    end
    start = 1'b0;
    chk1("ws_c13_done", done, 1'b1);
    chk1("ws_c13_read", avm_read, 1'b0);
    chk1("ws_pass", pass, 1'b1);
    chk("ws_id_value", id_value, 32'h0);

    // Reset while in FIN clears results immediately
    #2;
    reset_n = 1'b0;
    #1;
    chk1("rfin_done", done, 1'b0);
    chk1("rfin_pass", pass, 1'b0);
    chk("rfin_ts_value", ts_value, 32'h0);

    // Reset during an RD_ID stall abandons the read; auto check reruns after release
    reset_n = 1'b1;
    step();
    step();
    chk1("rst_mid_read_pre", avm_read, 1'b1);
    chk1("rst_mid_addr_pre", avm_address, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk1("rst_mid_read", avm_read, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_id_value", id_value, 32'h0);
    wait_states = 0;
    step();
    #2;
    reset_n = 1'b1;
    step();
    step();
    chk1("rerun_c2_done", done, 1'b0);
    step();
    chk1("rerun_c3_done", done, 1'b1);
    chk1("rerun_pass", pass, 1'b1);
    chk("rerun_ts_value", ts_value, 32'h606A_5FA0);

    // Stuck waitrequest with TIMEOUT_CYCLES=4: read high for cycles 1..4, FIN at cycle 5
    #2;
    reset2_n = 1'b1;
    step();
    for (int c = 1; c <= 4; c++) begin
      chk1($sformatf("to_c%0d_read", c), t_read, 1'b1);
      chk1($sformatf("to_c%0d_addr", c), t_address, 1'b0);
      chk1($sformatf("to_c%0d_timeout", c), t_timeout, 1'b0);
      step();
    end
    chk1("to_c5_read", t_read, 1'b0);
    chk1("to_c5_busy", t_busy, 1'b0);
    chk1("to_done", t_done, 1'b1);
    chk1("to_timeout", t_timeout, 1'b1);
    chk1("to_pass", t_pass, 1'b0);
    chk1("to_id_ok", t_id_ok, 1'b0);
    chk1("to_ts_ok", t_ts_ok, 1'b0);
    chk("to_id_value", t_id_value, 32'h0);
    chk("to_ts_value", t_ts_value, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sysid_check_master.md
SYSID_CHECK_MASTER -- requirements
Module: sysid_check_master

Interface
REQ-001 The block SHALL have the following parameters:
- EXPECTED_ID, default 32'h00000000, expected system ID word at slave address 0.
- EXPECTED_TS, default 32'h606A5FA0, expected timestamp word at slave address 1.
- TIMEOUT_CYCLES, default 255, maximum stalled cycles per read; range 1..65535.
REQ-002 The block SHALL have the following ports:
- clock  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to re-run the check.
- avm_address  out  1  Avalon-MM word address (0 = ID, 1 = timestamp).
- avm_read  out  1  Avalon-MM read strobe.
- avm_waitrequest  in  1  slave stall; tie 0 for a zero-wait slave.
- avm_readdata  in  32  read data, valid in any cycle with avm_read=1 and avm_waitrequest=0.
- busy  out  1  check in progress.
- done  out  1  check finished; result outputs valid.
- pass  out  1  id_ok AND ts_ok AND NOT timeout.
- id_ok  out  1  captured ID equals EXPECTED_ID.
- ts_ok  out  1  captured timestamp equals EXPECTED_TS.
- timeout  out  1  a read exceeded TIMEOUT_CYCLES.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.

Function
REQ-003 The FSM SHALL have the states IDLE, RD_ID, RD_TS and FIN.
REQ-004 The FSM SHALL transition IDLE->RD_ID unconditionally on the first clock after reset release, so that one check runs automatically.
REQ-005 In RD_ID the block SHALL drive avm_read=1 and avm_address=0, and SHALL hold both stable while avm_waitrequest=1.
REQ-006 In RD_ID, when avm_waitrequest=0, the block SHALL capture avm_readdata into id_value and move to RD_TS on the next edge, with no idle cycle between reads.
REQ-007 In RD_TS the block SHALL drive avm_read=1 and avm_address=1; when avm_waitrequest=0 it SHALL capture ts_value and move to FIN.
REQ-008 In IDLE and FIN the block SHALL drive avm_read=0 and avm_address=0.
REQ-009 busy SHALL be 1 exactly in RD_ID and RD_TS; done SHALL be 1 exactly in FIN.
REQ-010 With zero wait states, done SHALL rise 3 clocks after the first post-reset edge: IDLE, RD_ID, RD_TS, FIN.
REQ-011 id_ok, ts_ok and pass SHALL be registered flags, updated on the same edge that captures the corresponding word and on FIN entry.
REQ-012 A 16-bit stall counter SHALL clear on every state entry and increment each cycle avm_read=1 and avm_waitrequest=1.
REQ-013 When the stall counter equals TIMEOUT_CYCLES while still stalled, the block SHALL deassert avm_read, set timeout=1 and enter FIN.
REQ-014 On a timeout, any word not yet captured SHALL keep the value 0 and its _ok flag SHALL be 0; pass SHALL be 0.
REQ-015 start SHALL be ignored in RD_ID and RD_TS.
REQ-016 start in FIN or IDLE SHALL clear done, timeout, id_ok, ts_ok, pass, id_value and ts_value, and enter RD_ID on the next edge.
REQ-017 Equality compares SHALL be full 32-bit; the block SHALL perform no partial-word or byte-enable reads.

Reset
REQ-018 Asserting reset_n=0 SHALL immediately force state IDLE and all outputs to 0, including avm_read, avm_address, id_value and ts_value.
REQ-019 Reset asserted mid-read SHALL abandon the transaction with no capture; the automatic check restarts after release.
REQ-020 The stall counter SHALL reset to 0.

Structure
REQ-021 The state encoding and the address constants ADDR_ID=0 and ADDR_TS=1 SHALL reside in a shared package, sysid_pkg.
REQ-022 The block SHALL be a single module with no sub-modules; the stall counter is inline.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Zero-wait slave returning 0 / 32'h606A5FA0 -> done at cycle 3; pass=1, id_ok=1, ts_ok=1.
- Slave returning ts 32'h606A5FA1 -> done=1, id_ok=1, ts_ok=0, pass=0, ts_value=32'h606A5FA1.
- 5-cycle waitrequest on each read -> avm_address/avm_read stable throughout; done at cycle 13; pass=1.
- waitrequest stuck high with TIMEOUT_CYCLES=4 -> avm_read drops after 4 stalled cycles; timeout=1, pass=0, id_value=0.
- start pulsed during RD_TS -> ignored; start pulsed in FIN -> flags clear, new 2-read sequence, done re-asserts.
- reset_n low during RD_ID stall -> outputs 0 immediately; after release, a full check reruns and passes.
